// File: rtl/posit_defines.sv
// Shared types and helpers for the positron datapath blocks.
package posit_defines;

  typedef enum logic {SER_IDLE, SER_STREAM} serializer_state_t;

  // Ceiling log2; log2(1) = 0, callers clamp where a zero width is unusable.
  function automatic int log2(input int n);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/positron_layer_serializer_result_bank.sv
// One ping-pong bank: per-lane result registers, lane-valid mask and full flag.
module positron_result_bank #(
  parameter int POSIT_WIDTH = 4,
  parameter int NB_POSITRON = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NB_POSITRON-1:0]          cap_en,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] cap_data,
  input  logic                            release_full,
  input  logic [IDX_WIDTH-1:0]            idx,
  output logic [POSIT_WIDTH-1:0]          rd_data,
  output logic [NB_POSITRON-1:0]          valid,
  output logic                            full,
  output logic                            complete
);

  logic [POSIT_WIDTH-1:0] mem [NB_POSITRON];
  logic [NB_POSITRON-1:0] valid_next;

  assign valid_next = valid | cap_en;
  // A bank that is full or draining never sees captures, so its mask stays 0.
  assign complete   = &valid_next;
  assign rd_data    = mem[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      full  <= 1'b0;
    end else if (complete) begin
      valid <= '0;
      full  <= 1'b1;
    end else begin
      valid <= valid_next;
      if (release_full) full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB_POSITRON; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NB_POSITRON; i++) begin
        if (cap_en[i]) mem[i] <= cap_data[i*POSIT_WIDTH +: POSIT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/positron_layer_serializer.sv
// Gathers one end-of-window posit per upstream lane into a ping-pong bank and
// replays each completed bank as a single serial window to the next layer.
module positron_layer_serializer
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 4,
  parameter int NB_POSITRON = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_POSITRON-1:0]             rts_i,
  input  logic [NB_POSITRON-1:0]             eow_i,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
  output logic [NB_POSITRON-1:0]             rtr_o,
  input  logic                               rtr_i,
  output logic                               rts_o,
  output logic                               sow_o,
  output logic                               eow_o,
  output logic [POSIT_WIDTH-1:0]             posit_o
);

  localparam int IDX_WIDTH = (log2(NB_POSITRON) < 1) ? 1 : log2(NB_POSITRON);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB_POSITRON - 1);
  localparam logic [0:0] ST_IDLE   = 1'(SER_IDLE);
  localparam logic [0:0] ST_STREAM = 1'(SER_STREAM);

  logic [0:0]             state;
  logic                   fill_ptr;
  logic                   drain_ptr;
  logic [IDX_WIDTH-1:0]   idx;
  logic [NB_POSITRON-1:0] cap;
  logic                   streaming;
  logic                   last_beat;
  logic                   release_drain;

  logic [1:0]             bank_full;
  logic [1:0]             bank_complete;
  logic [NB_POSITRON-1:0] bank_valid [2];
  logic [POSIT_WIDTH-1:0] bank_rd    [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    positron_result_bank #(
      .POSIT_WIDTH (POSIT_WIDTH),
      .NB_POSITRON (NB_POSITRON),
      .IDX_WIDTH   (IDX_WIDTH)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .cap_en       ((fill_ptr == 1'(b)) ? cap : '0),
      .cap_data     (posit_i),
      .release_full (release_drain && (drain_ptr == 1'(b))),
      .idx          (idx),
      .rd_data      (bank_rd[b]),
      .valid        (bank_valid[b]),
      .full         (bank_full[b]),
      .complete     (bank_complete[b])
    );
  end

  // Ready comes only from registered bank state; rts_i never reaches rtr_o.
  assign rtr_o = (rst || bank_full[fill_ptr]) ? '0 : ~bank_valid[fill_ptr];
  assign cap   = rts_i & eow_i & rtr_o;

  assign streaming     = (state == ST_STREAM);
  assign last_beat     = (idx == LAST_IDX);
  assign release_drain = streaming && rtr_i && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_ptr <= 1'b0;
    end else if (bank_complete[fill_ptr]) begin
      fill_ptr <= ~fill_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      drain_ptr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bank_full[drain_ptr]) begin
            state <= ST_STREAM;
            idx   <= '0;
          end
        end
        default: begin
          if (rtr_i) begin
            if (last_beat) begin
              state     <= ST_IDLE;
              idx       <= '0;
              drain_ptr <= ~drain_ptr;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign rts_o   = streaming;
  assign sow_o   = streaming && (idx == '0);
  assign eow_o   = streaming && last_beat;
  assign posit_o = streaming ? bank_rd[drain_ptr] : '0;

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Scoreboard bench for the layer serializer with NB_POSITRON=4, POSIT_WIDTH=4.
module tb_positron_layer_serializer;

  localparam int PW = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] rts_i = '0;
  logic [NB-1:0] eow_i = '0;
  logic [NB*PW-1:0] posit_i = '0;
  logic [NB-1:0] rtr_o;
  logic          rtr_i = 1'b0;
  logic          rts_o;
  logic          sow_o;
  logic          eow_o;
  logic [PW-1:0] posit_o;

  typedef struct packed {
    logic [PW-1:0] posit;
    logic          sow;
    logic          eow;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_xfer   = 0;

  positron_layer_serializer #(.POSIT_WIDTH(PW), .NB_POSITRON(NB)) dut (
    .clk     (clk),
    .rst     (rst),
    .rts_i   (rts_i),
    .eow_i   (eow_i),
    .posit_i (posit_i),
    .rtr_o   (rtr_o),
    .rtr_i   (rtr_i),
    .rts_o   (rts_o),
    .sow_o   (sow_o),
    .eow_o   (eow_o),
    .posit_o (posit_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor samples on the falling edge; a beat transfers at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rts_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_rts", 32'(rts_o), 32'd0);
        end else begin
          mon_e = exp_q[0];
          check(rtr_i ? "beat_posit" : "hold_posit", 32'(posit_o), 32'(mon_e.posit));
          check(rtr_i ? "beat_sow" : "hold_sow", 32'(sow_o), 32'(mon_e.sow));
          check(rtr_i ? "beat_eow" : "hold_eow", 32'(eow_o), 32'(mon_e.eow));
          if (rtr_i) begin
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end else begin
        check("idle_outputs", 32'({sow_o, eow_o, posit_o}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input logic [NB*PW-1:0] w);
    beat_t b;
    for (int i = 0; i < NB; i++) begin
      b.posit = w[i*PW +: PW];
      b.sow   = (i == 0);
      b.eow   = (i == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic offer_window(input logic [NB*PW-1:0] w, input string tag);
    int n = 0;
    rts_i   = '1;
    eow_i   = '1;
    posit_i = w;
    while (rtr_o != '1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, "_accept_timeout"}, 32'(rtr_o), 32'hF);
    @(posedge clk);
    #1;
    rts_i = '0;
    eow_i = '0;
    push_window(w);
  endtask

  task automatic offer_lane(input int lane, input logic [PW-1:0] d);
    int n = 0;
    rts_i[lane] = 1'b1;
    eow_i[lane] = 1'b1;
    posit_i[lane*PW +: PW] = d;
    while (!rtr_o[lane] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("lane_accept_timeout", 32'(rtr_o[lane]), 32'd1);
    @(posedge clk);
    #1;
    rts_i = '0;
    eow_i = '0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rts_o) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int n;

    // Reset values
    tick(); tick(); tick();
    check("rst_rts", 32'(rts_o), 32'd0);
    check("rst_sow_eow", 32'({sow_o, eow_o}), 32'd0);
    check("rst_posit", 32'(posit_o), 32'd0);
    check("rst_rtr", 32'(rtr_o), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rtr", 32'(rtr_o), 32'hF);

    // Basic window, with first-beat latency
    rtr_i = 1'b1;
    offer_window(16'h4321, "basic");
    check("lat_idle", 32'(rts_o), 32'd0);
    tick();
    check("lat_stream", 32'(rts_o), 32'd1);
    check("lat_sow", 32'(sow_o), 32'd1);
    wait_drain("basic");

    // Out-of-order lanes 3,1,0,2
    offer_lane(3, 4'hA);
    offer_lane(1, 4'hB);
    offer_lane(0, 4'hC);
    tick(); tick();
    check("ooo_quiet", 32'(rts_o), 32'd0);
    check("ooo_rtr", 32'(rtr_o), 32'h4);
    offer_lane(2, 4'hD);
    push_window(16'hADBC);
    wait_drain("ooo");

    // Back-pressure pattern 1,0,0,1
    rtr_i = 1'b0;
    base  = n_xfer;
    offer_window(16'h8765, "bp");
    for (int c = 0; c < 60 && (exp_q.size() != 0 || rts_o); c++) begin
      rtr_i = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
    end
    check("bp_xfers", 32'(n_xfer - base), 32'd4);
    rtr_i = 1'b1;
    wait_drain("bp");

    // Ping-pong: both banks full blocks a third window
    rtr_i = 1'b0;
    offer_window(16'hCBA9, "pp1");
    offer_window(16'h0FED, "pp2");
    rts_i   = '1;
    eow_i   = '1;
    posit_i = 16'h3521;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("pp_blocked", 32'(rtr_o), 32'd0);
    end
    check("pp_stall_head", 32'(posit_o), 32'h9);
    rtr_i = 1'b1;
    offer_window(16'h3521, "pp3");
    wait_drain("pp");

    // No-eow beat ignored; repeated lane result held off
    rtr_i = 1'b1;
    rts_i[0] = 1'b1;
    eow_i[0] = 1'b0;
    posit_i[3:0] = 4'h7;
    tick();
    rts_i = '0;
    check("noeow_rtr", 32'(rtr_o), 32'hF);
    offer_lane(0, 4'h1);
    check("repeat_rtr", 32'(rtr_o), 32'hE);
    rts_i[0] = 1'b1;
    eow_i[0] = 1'b1;
    posit_i[3:0] = 4'h9;
    tick(); tick();
    check("repeat_held", 32'(rtr_o), 32'hE);
    rts_i = '0;
    eow_i = '0;
    offer_lane(1, 4'h2);
    offer_lane(2, 4'h3);
    offer_lane(3, 4'h4);
    push_window(16'h4321);
    wait_drain("repeat");

    // Reset after beat 1 of a window
    base = n_xfer;
    offer_window(16'hDCBA, "rs");
    n = 0;
    while ((n_xfer - base) < 2 && n < 50) begin
      tick();
      n++;
    end
    check("rs_two_beats", 32'(n_xfer - base), 32'd2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("rs_rts", 32'(rts_o), 32'd0);
    check("rs_sow_eow", 32'({sow_o, eow_o}), 32'd0);
    check("rs_posit", 32'(posit_o), 32'd0);
    check("rs_rtr", 32'(rtr_o), 32'd0);
    tick(); tick();
    check("rs_held_eow", 32'(eow_o), 32'd0);
    rst = 1'b0;
    #1;
    check("rs_release_rtr", 32'(rtr_o), 32'hF);
    tick();
    offer_window(16'h1357, "post_rst");
    wait_drain("post_rst");

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/positron_layer_serializer.md
# positron_layer_serializer

Collects the single end-of-window result posit emitted by each of `NB_POSITRON` parallel positrons of one layer and retransmits them as one serial window (`sow_o` on the first beat, `eow_o` on the last) for the next layer's positrons. It is the transmitter end of the positron stream protocol (`rts`/`rtr`/`sow`/`eow`/posit), placed between two layers. Ping-pong buffering lets layer k+1 consume window n while layer k produces window n+1.

## Interface
Parameters:
- `POSIT_WIDTH`, 4: posit word width; the data is opaque and NaR passes through unchanged.
- `NB_POSITRON`, 16: number of upstream positrons, which is also the number of beats in each output window. Must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rts_i`  in  NB_POSITRON  per-lane valid from upstream positron i.
- `eow_i`  in  NB_POSITRON  per-lane end-of-window marking the result beat.
- `posit_i`  in  NB_POSITRON*POSIT_WIDTH  lane i occupies bits [i*POSIT_WIDTH +: POSIT_WIDTH].
- `rtr_o`  out  NB_POSITRON  per-lane ready.
- `rtr_i`  in  1  downstream ready.
- `rts_o`  out  1  output beat valid.
- `sow_o`  out  1  first beat of the window.
- `eow_o`  out  1  last beat of the window.
- `posit_o`  out  POSIT_WIDTH  output posit.

## Operation
- Storage is two banks. Each bank holds NB_POSITRON posit registers, a lane-valid mask and a `full` flag.
- Pointers:
  - `fill_ptr` selects the bank being written.
  - `drain_ptr` selects the bank being read.
  - Both pointers reset to 0.
- Lane capture:
  - Lane i is captured when `rts_i[i] & eow_i[i] & rtr_o[i]`. The posit is stored and `valid[fill_ptr][i]` is set.
  - `rts_i[i]` without `eow_i[i]` is ignored and nothing is stored.
- Ready:
  - `rtr_o[i] = ~rst & ~full[fill_ptr] & ~valid[fill_ptr][i]`.
  - A second result on an already-filled lane is back-pressured until the bank swaps.
- Bank completion:
  - When the mask, including captures in the current cycle, becomes all ones: set `full[fill_ptr]`, clear that bank's mask, and toggle `fill_ptr`.
  - If the other bank is still full, `rtr_o` is 0 on all lanes until it drains.
- Drain FSM, `IDLE`/`STREAM`, with index counter `idx` of width log2(NB_POSITRON), minimum 1:
  - `IDLE`: if `full[drain_ptr]`, go to `STREAM` with `idx=0`.
  - `STREAM`:
    - `rts_o=1`.
    - `posit_o = bank[drain_ptr][idx]`.
    - `sow_o = (idx==0)`.
    - `eow_o = (idx==NB_POSITRON-1)`.
    - A beat transfers on `rts_o & rtr_i`.
    - Non-last beat transfer: `idx++`.
    - Last beat transfer: clear `full[drain_ptr]`, toggle `drain_ptr`, go to `IDLE`.
- In `IDLE`: `rts_o`, `sow_o` and `eow_o` are 0, and `posit_o` is 0.
- Simultaneous events:
  - Last-beat drain of bank A and completion of bank B in the same cycle are both honoured.
  - A bank that is being freed is never written in the cycle it is freed.
- `NB_POSITRON=1`: every beat has `sow_o=eow_o=1`.

## Timing
- Reset values:
  - `rts_o`, `sow_o`, `eow_o` and `posit_o` are 0.
  - `rtr_o` is all 0 while `rst` is high, and all 1 in the first cycle after release.
  - All masks, `full` flags, pointers and `idx` are 0, and the FSM is in `IDLE`.
- Latency: if the completing capture occurs at edge E, `full` is set at E, the FSM enters `STREAM` at E+1, and the first beat is visible after E+1.
- Throughput: one beat per cycle while `rtr_i=1`. Between consecutive windows there is one `IDLE` cycle.
- Output hold: `posit_o`, `sow_o` and `eow_o` are registered or derived from registered state, and stay stable while `rts_o & ~rtr_i`.
- Capture is a same-cycle handshake. `rtr_o` depends combinationally only on registered state, with no path from `rts_i`.
- Reset mid-operation: the partial fill and any in-flight window are discarded. No `eow_o` is emitted for the discarded window.

## Structure
- Add to `posit_defines`:
  - `typedef enum logic {SER_IDLE, SER_STREAM} serializer_state_t`.
  - Reuse the existing `log2` function for the `idx` width.
- Sub-module `positron_result_bank`, instantiated twice. It contains:
  - The posit register array.
  - The lane-valid mask and the `full` flag.
  - The capture inputs: lane enable vector and data bus.
  - A `release` input that clears `full`.
  - A read port indexed by `idx`.
- The top level holds the pointers, the FSM, `idx`, the lane/ready muxing and the output registers.

## Test plan
Settings: `POSIT_WIDTH=4`, `NB_POSITRON=4`.
- Basic window: lanes 0–3 are presented with `rts_i=eow_i=1` in the same cycle, data 0x1,0x2,0x3,0x4, with `rtr_i=1` → two cycles later, 4 consecutive beats 1,2,3,4; `sow_o` on beat 0 and `eow_o` on beat 3.
- Out-of-order lanes: lanes 3,1,0,2 are captured on separate cycles with data 0xA,0xB,0xC,0xD → output order is lane order C,B,D,A. Nothing is emitted before lane 2 is captured.
- Back-pressure: `rtr_i` toggles 1,0,0,1,… during `STREAM` → each beat is held stable while `rtr_i=0`. There are exactly 4 transfers and the `sow_o`/`eow_o` positions are unchanged.
- Ping-pong full: `rtr_i=0`, three full windows are offered → the first two are captured and all `rtr_o` are 0 for the third. After `rtr_i=1` drains window 1, the third window is accepted. The output sequence is windows 1, 2, 3 in order.
- Repeat lane / no-eow: lane 0 asserts `rts_i` with `eow_i=0` (0x7) → it is ignored. A second `eow_i` result on lane 0 before the bank completes is held off by `rtr_o[0]=0`.
- Reset mid-stream: assert `rst` after beat 1 of a window → all outputs go to 0 immediately and no `eow_o` is emitted. A subsequent full window streams normally starting from bank 0.
